pulse_period_meter: RTL

- Measurement end of the divider chain: takes the pulse train from a preset-loadable up/down counter (carry/borrow or toggle-FF output) and recovers the divide ratio as a CLK-cycle count.
- Synchronises the asynchronous pulse input, detects rising edges and counts CLK cycles between consecutive edges.
- Reports each completed period with a one-cycle valid strobe, an overflow flag and a compare-match against an expected ratio.
- Used in lab benches to check the divider's output period against the loaded preset value.

---
 rtl/pmeter_pkg.sv | 10 +
 rtl/pin_sync_edge.sv | 27 ++
 rtl/pulse_period_meter.sv | 109 ++++++++++
 3 files changed

// File: rtl/pmeter_pkg.sv
// Shared types and constants for the pulse period meter.
package pmeter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned CNT_MAX    = (1 << DEF_WIDTH) - 1;
  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchroniser for the asynchronous pulse input, followed by an
// edge flop that flags each synchronised rising edge for one cycle.
module pin_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PIN,
  output logic RISE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PIN};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign RISE = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures CLK cycles between successive rising edges of PIN and reports each period.
// Optional running min/max tracking is enabled by defining PULSE_PERIOD_METER_MINMAX_EN.
module pulse_period_meter
  import pmeter_pkg::*;
#(
  parameter int unsigned WIDTH       = $clog2(CNT_MAX + 1),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             PIN,
  input  logic [WIDTH-1:0] EXPECT,
`ifdef PULSE_PERIOD_METER_MINMAX_EN
  input  logic             CLR_MM,
  output logic [WIDTH-1:0] PMIN,
  output logic [WIDTH-1:0] PMAX,
`endif
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             OVF,
  output logic             MATCH,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] CntMax = '1;
  // The edge cycle itself is the first cycle of the new period.
  localparam logic [WIDTH-1:0] CntReload = WIDTH'(MIN_PERIOD - 1);

  logic             rise;
  logic             at_max;
  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;

  pin_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .PIN  (PIN),
    .RISE (rise)
  );

  assign at_max = (cnt_q == CntMax);
  assign BUSY   = (state_q == MEAS);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      PERIOD  <= '0;
      VALID   <= 1'b0;
      OVF     <= 1'b0;
      MATCH   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (EN) state_q <= ARM;
        end
        ARM: begin
          if (!EN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (rise) begin
            state_q <= MEAS;
            cnt_q   <= CntReload;
          end
        end
        MEAS: begin
          if (!EN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (rise) begin
            PERIOD <= cnt_q;
            OVF    <= at_max;
            MATCH  <= (cnt_q == EXPECT) && !at_max;
            VALID  <= 1'b1;
            cnt_q  <= CntReload;
          end else if (!at_max) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef PULSE_PERIOD_METER_MINMAX_EN
  logic capture;
  assign capture = (state_q == MEAS) && EN && rise;

  // Clear wins over a capture landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR_MM) begin
      PMIN <= '1;
      PMAX <= '0;
    end else if (capture) begin
      if (cnt_q < PMIN) PMIN <= cnt_q;
      if (cnt_q > PMAX) PMAX <= cnt_q;
    end
  end
`endif

endmodule
